sc_proc_fetch: RTL and testbench

SC_PROC_FETCH -- requirements
Module: sc_proc_fetch

---
 rtl/sc_proc_fetch.sv | 133 +++++++++++++
 tb/tb_sc_proc_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_proc_fetch.sv
// Single-cycle processor fetch stage: requests instruction words from imem,
// holds the decoded fields stable, and strobes lock once per committed instruction.
module sc_proc_fetch #(
    parameter int unsigned      DBITS        = 32,
    parameter int unsigned      OP_BIT_WIDTH = 4,
    parameter logic [DBITS-1:0] START_PC     = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    output logic                    imem_req,
    output logic [DBITS-1:0]        imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    input  logic                    useImmPc,
    input  logic [DBITS-1:0]        pcIn,
    output logic                    lock,
    output logic [DBITS-1:0]        pcOut,
    output logic [OP_BIT_WIDTH-1:0] op1,
    output logic [OP_BIT_WIDTH-1:0] op2,
    output logic [3:0]              rd,
    output logic [3:0]              rs1,
    output logic [3:0]              rs2,
    output logic [DBITS-1:0]        imm32,
    output logic [31:0]             instRetired
);

    localparam int unsigned IW = 32;
    localparam int unsigned CW = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       stateReg;
    logic [1:0]       stateNext;
    logic             loadIr;
    logic             commitNow;

    logic [DBITS-1:0] pcReg;
    logic [DBITS-1:0] pcNext;
    logic [DBITS-1:0] redirectPc;
    logic [IW-1:0]    irReg;
    logic [DBITS-1:0] pcOutReg;
    logic [CW-1:0]    retiredReg;
    logic             imemReqReg;
    logic             lockReg;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic; ack only matters while the request is outstanding
    always_comb begin
        stateNext = stateReg;
        loadIr    = 1'b0;
        commitNow = 1'b0;
        case (stateReg)
            IDLE: begin
                if (run) begin
                    stateNext = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    loadIr    = 1'b1;
                    stateNext = COMMIT;
                end
            end
            COMMIT: begin
                commitNow = 1'b1;
                stateNext = run ? FETCH : IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Redirect targets are forced word-aligned
    assign redirectPc = pcIn & ~DBITS'(3);
    assign pcNext     = useImmPc ? redirectPc : pcReg + DBITS'(4);

    // Request and commit strobes registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imemReqReg <= 1'b0;
            lockReg    <= 1'b0;
        end else begin
            imemReqReg <= (stateNext == FETCH);
            lockReg    <= (stateNext == COMMIT);
        end
    end

    // Architectural state: pc, instruction register, return address, retire count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcReg      <= START_PC;
            irReg      <= '0;
            pcOutReg   <= START_PC + DBITS'(4);
            retiredReg <= '0;
        end else begin
            if (loadIr) begin
                irReg    <= imem_rdata;
                pcOutReg <= pcReg + DBITS'(4);
            end
            if (commitNow) begin
                pcReg      <= pcNext;
                retiredReg <= retiredReg + CW'(1);
            end
        end
    end

    assign imem_req    = imemReqReg;
    assign imem_addr   = pcReg;
    assign lock        = lockReg;
    assign pcOut       = pcOutReg;
    assign instRetired = retiredReg;

    // Decode fields are slices of the held instruction word
    assign op1   = OP_BIT_WIDTH'(irReg[31:28]);
    assign op2   = OP_BIT_WIDTH'(irReg[27:24]);
    assign rd    = irReg[23:20];
    assign rs1   = irReg[19:16];
    assign rs2   = irReg[15:12];
    assign imm32 = {{(DBITS-16){irReg[15]}}, irReg[15:0]};

endmodule

// File: tb/tb_sc_proc_fetch.sv
// Directed bench for sc_proc_fetch: per-cycle vector table plus reset and run-drop sequences.
module tb_sc_proc_fetch;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        useImmPc;
    logic [31:0] pcIn;
    logic        lock;
    logic [31:0] pcOut;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm32;
    logic [31:0] instRetired;

    int checks;
    int failures;

    sc_proc_fetch #(.DBITS(32), .OP_BIT_WIDTH(4), .START_PC(32'h0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .useImmPc    (useImmPc),
        .pcIn        (pcIn),
        .lock        (lock),
        .pcOut       (pcOut),
        .op1         (op1),
        .op2         (op2),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm32       (imm32),
        .instRetired (instRetired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        ack;
        logic [31:0] rdata;
        logic        useImm;
        logic [31:0] pcIn;
        logic        expReq;
        logic        expLock;
        logic [31:0] expAddr;
        logic [31:0] expPcOut;
        logic [31:0] expRet;
        logic [19:0] expDec;
        logic [31:0] expImm;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic u, logic [31:0] p,
                                logic eq, logic el, logic [31:0] ea, logic [31:0] epo,
                                logic [31:0] er, logic [19:0] ed, logic [31:0] ei);
        vec_t v;
        v.run = r; v.ack = a; v.rdata = d; v.useImm = u; v.pcIn = p;
        v.expReq = eq; v.expLock = el; v.expAddr = ea; v.expPcOut = epo;
        v.expRet = er; v.expDec = ed; v.expImm = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] decNow();
        return {op1, op2, rd, rs1, rs2};
    endfunction

    int lockCount;

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        run = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        useImmPc = 1'b0;
        pcIn = 32'h0;

        //          run ack rdata        use pcIn         req lck addr         pcOut        ret    dec       imm
        vecs[0]  = mk(1, 1, 32'hDEADBEEF, 0, 32'h0,        1, 0, 32'h0,        32'h4,       32'd0, 20'h0,     32'h0);
        vecs[1]  = mk(1, 1, 32'h8312FFFF, 0, 32'h0,        0, 1, 32'h0,        32'h4,       32'd0, 20'h8312F, 32'hFFFFFFFF);
        vecs[2]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h4,        32'h4,       32'd1, 20'h8312F, 32'hFFFFFFFF);
        vecs[3]  = mk(1, 0, 32'h0,        1, 32'h500,      1, 0, 32'h4,        32'h4,       32'd1, 20'h8312F, 32'hFFFFFFFF);
        vecs[4]  = mk(1, 0, 32'h0,        1, 32'h500,      1, 0, 32'h4,        32'h4,       32'd1, 20'h8312F, 32'hFFFFFFFF);
        vecs[5]  = mk(1, 0, 32'h0,        1, 32'h500,      1, 0, 32'h4,        32'h4,       32'd1, 20'h8312F, 32'hFFFFFFFF);
        vecs[6]  = mk(1, 1, 32'h12348001, 1, 32'h500,      0, 1, 32'h4,        32'h8,       32'd1, 20'h12348, 32'hFFFF8001);
        vecs[7]  = mk(1, 0, 32'h0,        1, 32'h103,      1, 0, 32'h100,      32'h8,       32'd2, 20'h12348, 32'hFFFF8001);
        vecs[8]  = mk(1, 1, 32'h00007FFF, 0, 32'h0,        0, 1, 32'h100,      32'h104,     32'd2, 20'h00007, 32'h00007FFF);
        vecs[9]  = mk(1, 0, 32'h0,        1, 32'hFFFFFFFE, 1, 0, 32'hFFFFFFFC, 32'h104,     32'd3, 20'h00007, 32'h00007FFF);
        vecs[10] = mk(1, 1, 32'hA5C31234, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 32'h0,       32'd3, 20'hA5C31, 32'h00001234);
        vecs[11] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,       32'd4, 20'hA5C31, 32'h00001234);
        vecs[12] = mk(1, 1, 32'h0F0F0F0F, 0, 32'h0,        0, 1, 32'h0,        32'h4,       32'd4, 20'h0F0F0, 32'h00000F0F);
        vecs[13] = mk(1, 0, 32'h0,        1, 32'h0,        1, 0, 32'h0,        32'h4,       32'd5, 20'h0F0F0, 32'h00000F0F);
        vecs[14] = mk(0, 1, 32'h11112222, 0, 32'h0,        0, 1, 32'h0,        32'h4,       32'd5, 20'h11112, 32'h00002222);
        vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h4,        32'h4,       32'd6, 20'h11112, 32'h00002222);
        vecs[16] = mk(0, 1, 32'hFFFFFFFF, 0, 32'h0,        0, 0, 32'h4,        32'h4,       32'd6, 20'h11112, 32'h00002222);
        vecs[17] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h4,        32'h4,       32'd6, 20'h11112, 32'h00002222);

        repeat (3) step();
        reset_n = 1'b1;

        // Reset values, checked before the first edge after release
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_lock",  32'(lock), 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_pcout", pcOut, 32'h4);
        chk("rst_ret",   instRetired, 32'd0);
        chk("rst_imm",   imm32, 32'h0);

        for (int i = 0; i < NV; i++) begin
            run = vecs[i].run;
            imem_ack = vecs[i].ack;
            imem_rdata = vecs[i].rdata;
            useImmPc = vecs[i].useImm;
            pcIn = vecs[i].pcIn;
            step();
            chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(vecs[i].expReq));
            chk($sformatf("v%0d_lock", i),  32'(lock), 32'(vecs[i].expLock));
            chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].expAddr);
            chk($sformatf("v%0d_pcout", i), pcOut, vecs[i].expPcOut);
            chk($sformatf("v%0d_ret", i),   instRetired, vecs[i].expRet);
            chk($sformatf("v%0d_dec", i),   32'(decNow()), 32'(vecs[i].expDec));
            chk($sformatf("v%0d_imm", i),   imm32, vecs[i].expImm);
        end

        // Reset mid-FETCH drops the request at once; a late ack is ignored
        run = 1'b0;
        imem_ack = 1'b0;
        useImmPc = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_req_async", 32'(imem_req), 32'd0);
        chk("mrst_addr",      imem_addr, 32'h0);
        chk("mrst_ret",       instRetired, 32'd0);
        chk("mrst_pcout",     pcOut, 32'h4);
        imem_ack = 1'b1;
        imem_rdata = 32'h76543210;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("late_ack%0d_req", c),  32'(imem_req), 32'd0);
            chk($sformatf("late_ack%0d_lock", c), 32'(lock), 32'd0);
        end
        chk("late_ack_ret",  instRetired, 32'd0);
        chk("late_ack_addr", imem_addr, 32'h0);
        chk("late_ack_dec",  32'(decNow()), 32'd0);
        imem_ack = 1'b0;

        // Run dropped during FETCH: the outstanding fetch still commits exactly once
        run = 1'b1;
        step();
        chk("rdrop_req0", 32'(imem_req), 32'd1);
        run = 1'b0;
        step();
        chk("rdrop_req1", 32'(imem_req), 32'd1);
        step();
        chk("rdrop_req2", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        imem_rdata = 32'h22223333;
        lockCount = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            imem_ack = 1'b0;
            if (lock) lockCount++;
            if (c > 0) chk($sformatf("rdrop_idle%0d_req", c), 32'(imem_req), 32'd0);
        end
        chk("rdrop_lock_pulses", 32'(lockCount), 32'd1);
        chk("rdrop_ret",   instRetired, 32'd1);
        chk("rdrop_addr",  imem_addr, 32'h4);
        chk("rdrop_imm",   imm32, 32'h00003333);
        run = 1'b1;
        step();
        chk("rdrop_resume_req",  32'(imem_req), 32'd1);
        chk("rdrop_resume_addr", imem_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
